// File: rtl/tens_complement_pkg.sv
// Shared types and constants for the serial BCD ten's-complement decoder.
//   state_e        : decoder FSM states (COLLECT input digits, EMIT magnitude digits)
//   bcd_digit_t    : one BCD digit
//   BCD_MAX        : largest legal BCD digit value
//   SIGN_THRESHOLD : an MSD at or above this value marks a negative word
package tens_complement_pkg;

  typedef enum logic [0:0] {
    COLLECT,
    EMIT
  } state_e;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX        = 4'd9;
  localparam bcd_digit_t SIGN_THRESHOLD = 4'd5;

endpackage

// File: rtl/bcd_digit_complement.sv
// One digit of a BCD ten's-complement negation: nine's complement plus an incoming carry,
// wrapping 10 back to 0 and producing the carry for the next more-significant digit.
//   digit     : legal BCD digit (0..9)
//   carry_in  : +1 from the less-significant digit (1 for the LSD)
//   digit_out : resulting BCD digit
//   carry_out : 1 when the sum wrapped from 10 to 0
module bcd_digit_complement
  import tens_complement_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       carry_in,
  output logic [3:0] digit_out,
  output logic       carry_out
);

  logic [4:0] sum;

  always_comb begin
    sum       = (5'(BCD_MAX) - 5'(digit)) + 5'(carry_in);
    carry_out = (sum == 5'd10);
    digit_out = carry_out ? 4'd0 : sum[3:0];
  end

endmodule

// File: rtl/tens_complement_decoder.sv
// Serial BCD ten's-complement to sign-magnitude decoder.
// Collects NDIGITS digits (LSD first) over an input valid/ready stream, resolves the sign
// from the MSD, then emits the magnitude LSD first over an output valid/ready stream.
//   clk, rst                        : clock, synchronous active-high reset
//   in_valid/in_ready/in_digit      : input digit stream
//   out_valid/out_ready/out_digit   : output magnitude digit stream
//   out_sign                        : 1 = negative word (held for the whole output word)
//   out_last                        : marks the MSD output digit
//   out_err                         : the input word held a non-BCD digit
module tens_complement_decoder
  import tens_complement_pkg::*;
#(
  parameter int unsigned NDIGITS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_digit,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_digit,
  output logic       out_sign,
  output logic       out_last,
  output logic       out_err
);

  localparam int unsigned IdxW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NDIGITS - 1);

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic            neg_q, neg_d;
  logic            err_q, err_d;
  bcd_digit_t      digit_buf_q [NDIGITS];
  bcd_digit_t      digit_buf_d [NDIGITS];

  logic       in_fire, out_fire;
  logic       digit_ok;
  bcd_digit_t stored_digit;
  bcd_digit_t cur_digit;
  bcd_digit_t comp_digit;
  logic       comp_carry;

  // Outputs are forced idle while reset is held, even before the state register clears.
  assign in_ready  = !rst && (state_q == COLLECT);
  assign out_valid = !rst && (state_q == EMIT);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  assign digit_ok     = (in_digit <= BCD_MAX);
  assign stored_digit = digit_ok ? in_digit : '0;
  assign cur_digit    = digit_buf_q[idx_q];

  bcd_digit_complement u_complement (
    .digit     (cur_digit),
    .carry_in  (carry_q),
    .digit_out (comp_digit),
    .carry_out (comp_carry)
  );

  assign out_digit = out_valid ? (neg_q ? comp_digit : cur_digit) : '0;
  assign out_last  = out_valid && (idx_q == LastIdx);
  assign out_sign  = out_valid && neg_q;
  assign out_err   = out_valid && err_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    neg_d       = neg_q;
    err_d       = err_q;
    digit_buf_d = digit_buf_q;

    unique case (state_q)
      COLLECT: begin
        if (in_fire) begin
          digit_buf_d[idx_q] = stored_digit;
          if (!digit_ok) err_d = 1'b1;
          if (idx_q == LastIdx) begin
            // Sign is taken from the stored MSD, so an illegal MSD reads as 0 (positive).
            neg_d   = (stored_digit >= SIGN_THRESHOLD);
            idx_d   = '0;
            carry_d = 1'b1;
            state_d = EMIT;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      EMIT: begin
        if (out_fire) begin
          if (idx_q == LastIdx) begin
            state_d = COLLECT;
            idx_d   = '0;
            err_d   = 1'b0;
            neg_d   = 1'b0;
            carry_d = 1'b0;
          end else begin
            idx_d   = idx_q + 1'b1;
            carry_d = comp_carry;
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= COLLECT;
      idx_q       <= '0;
      carry_q     <= 1'b1;
      neg_q       <= 1'b0;
      err_q       <= 1'b0;
      digit_buf_q <= '{default: '0};
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      neg_q       <= neg_d;
      err_q       <= err_d;
      digit_buf_q <= digit_buf_d;
    end
  end

endmodule

// File: tb/tb_tens_complement_decoder.sv
// Self-checking bench for tens_complement_decoder (NDIGITS = 4).
// Expected words come from an arithmetic model pushed to a scoreboard queue at stimulus time.
module tb_tens_complement_decoder;

  localparam int N = 4;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_digit;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_digit;
  logic       out_sign;
  logic       out_last;
  logic       out_err;

  tens_complement_decoder #(.NDIGITS(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_digit  (in_digit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_digit (out_digit),
    .out_sign  (out_sign),
    .out_last  (out_last),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] mag;
    logic        sign;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_cmp;
  int   n_fail;

  function automatic logic [15:0] w4(input int d0, input int d1, input int d2, input int d3);
    return {4'(d3), 4'(d2), 4'(d1), 4'(d0)};
  endfunction

  // Value-level model: signed ten's-complement value -> sign and decimal magnitude.
  function automatic exp_t model(input logic [15:0] w);
    exp_t   e;
    longint v;
    longint p;
    int     dv;
    int     msd;
    e   = '0;
    v   = 0;
    p   = 1;
    msd = 0;
    for (int i = 0; i < N; i++) begin
      dv = int'(w[4*i +: 4]);
      if (dv > 9) begin
        e.err = 1'b1;
        dv    = 0;
      end
      v += longint'(dv) * p;
      p *= 10;
      msd = dv;
    end
    if (msd >= 5) v -= p;
    e.sign = (v < 0);
    if (v < 0) v = -v;
    for (int i = 0; i < N; i++) begin
      e.mag[4*i +: 4] = 4'(v % 10);
      v /= 10;
    end
    return e;
  endfunction

  // Drives n digits starting at a negedge; returns at a negedge after the last handshake.
  task automatic send_digits(input logic [15:0] w, input int n, input bit hold_valid);
    int k;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_digit = w[4*i +: 4];
      k = 0;
      while (!in_ready && k < 20) begin
        @(negedge clk);
        k++;
      end
      if (!in_ready) begin
        n_cmp++;
        n_fail++;
        $display("FAIL send_timeout: in_ready got 0 want 1 (digit %0d)", i);
      end
      @(negedge clk);
    end
    if (!hold_valid) in_valid = 1'b0;
  endtask

  // Collects one output word with out_ready held high; no checking here.
  task automatic recv_word(output logic [15:0] d, output logic [3:0] s, output logic [3:0] l,
                           output logic [3:0] e, output bit ok);
    int k;
    d  = '0;
    s  = '0;
    l  = '0;
    e  = '0;
    ok = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      k = 0;
      while (!out_valid && k < 20) begin
        @(negedge clk);
        k++;
      end
      if (!out_valid) begin
        ok = 1'b0;
        return;
      end
      d[4*i +: 4] = out_digit;
      s[i] = out_sign;
      l[i] = out_last;
      e[i] = out_err;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_digit  = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_digit !== 4'd0) begin n_fail++; $display("FAIL reset_out_digit: got %0d want 0", out_digit); end
    n_cmp++; if ({out_sign, out_last, out_err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {out_sign, out_last, out_err}); end
    rst = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
  endtask

  task automatic test_decode();
    logic [15:0] words[6];
    logic [15:0] od;
    logic [3:0]  os, ol, oe;
    bit          ok;
    exp_t        e;
    words[0] = w4(3, 2, 1, 0);
    words[1] = w4(7, 7, 8, 9);
    words[2] = w4(0, 9, 9, 9);
    words[3] = w4(0, 0, 0, 5);
    words[4] = w4(9, 9, 9, 4);
    words[5] = w4(0, 0, 0, 0);
    for (int w = 0; w < 6; w++) begin
      sb.push_back(model(words[w]));
      send_digits(words[w], N, 1'b0);
      n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL decode%0d_latency: out_valid got %b want 1", w, out_valid); end
      recv_word(od, os, ol, oe, ok);
      e = sb.pop_front();
      n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL decode%0d_timeout: got %b want 1", w, ok); end
      for (int i = 0; i < N; i++) begin
        n_cmp++; if (od[4*i +: 4] !== e.mag[4*i +: 4]) begin n_fail++; $display("FAIL decode%0d_digit%0d: got %0d want %0d", w, i, od[4*i +: 4], e.mag[4*i +: 4]); end
        n_cmp++; if (os[i] !== e.sign) begin n_fail++; $display("FAIL decode%0d_sign%0d: got %b want %b", w, i, os[i], e.sign); end
        n_cmp++; if (oe[i] !== e.err) begin n_fail++; $display("FAIL decode%0d_err%0d: got %b want %b", w, i, oe[i], e.err); end
        n_cmp++; if (ol[i] !== (i == N - 1)) begin n_fail++; $display("FAIL decode%0d_last%0d: got %b want %b", w, i, ol[i], (i == N - 1)); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] w;
    exp_t        e;
    int          k;
    w = w4(7, 7, 8, 9);
    sb.push_back(model(w));
    send_digits(w, N, 1'b1);
    in_digit  = 4'd5;  // would corrupt the next word if wrongly accepted during EMIT
    out_ready = 1'b1;
    e = sb.pop_front();
    for (int i = 0; i < N; i++) begin
      k = 0;
      while (!out_valid && k < 20) begin
        @(negedge clk);
        k++;
      end
      n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid%0d: got %b want 1", i, out_valid); end
      n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready%0d: got %b want 0", i, in_ready); end
      if (i == 1) begin
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
          n_cmp++; if (out_digit !== e.mag[7:4]) begin n_fail++; $display("FAIL bp_stall_digit c%0d: got %0d want %0d", c, out_digit, e.mag[7:4]); end
          n_cmp++; if ({out_sign, out_last, out_err} !== {e.sign, 1'b0, e.err}) begin n_fail++; $display("FAIL bp_stall_flags c%0d: got %b want %b", c, {out_sign, out_last, out_err}, {e.sign, 1'b0, e.err}); end
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
      n_cmp++; if (out_digit !== e.mag[4*i +: 4]) begin n_fail++; $display("FAIL bp_digit%0d: got %0d want %0d", i, out_digit, e.mag[4*i +: 4]); end
      n_cmp++; if (out_sign !== e.sign) begin n_fail++; $display("FAIL bp_sign%0d: got %b want %b", i, out_sign, e.sign); end
      n_cmp++; if (out_last !== (i == N - 1)) begin n_fail++; $display("FAIL bp_last%0d: got %b want %b", i, out_last, (i == N - 1)); end
      if (i == N - 1) in_valid = 1'b0;
      @(negedge clk);
    end
    n_cmp++; if ({in_ready, out_valid} !== 2'b10) begin n_fail++; $display("FAIL bp_after: in_ready,out_valid got %b want 10", {in_ready, out_valid}); end
  endtask

  task automatic test_invalid();
    logic [15:0] words[2];
    logic [15:0] od;
    logic [3:0]  os, ol, oe;
    bit          ok;
    exp_t        e;
    words[0] = w4(3, 10, 1, 0);
    words[1] = w4(3, 2, 1, 0);
    for (int w = 0; w < 2; w++) begin
      sb.push_back(model(words[w]));
      send_digits(words[w], N, 1'b0);
      recv_word(od, os, ol, oe, ok);
      e = sb.pop_front();
      n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL inv%0d_timeout: got %b want 1", w, ok); end
      for (int i = 0; i < N; i++) begin
        n_cmp++; if (od[4*i +: 4] !== e.mag[4*i +: 4]) begin n_fail++; $display("FAIL inv%0d_digit%0d: got %0d want %0d", w, i, od[4*i +: 4], e.mag[4*i +: 4]); end
        n_cmp++; if (oe[i] !== e.err) begin n_fail++; $display("FAIL inv%0d_err%0d: got %b want %b", w, i, oe[i], e.err); end
        n_cmp++; if (os[i] !== e.sign) begin n_fail++; $display("FAIL inv%0d_sign%0d: got %b want %b", w, i, os[i], e.sign); end
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [15:0] od;
    logic [3:0]  os, ol, oe;
    bit          ok;
    exp_t        e;
    logic [15:0] w;
    // Reset during COLLECT after two digits.
    send_digits(w4(7, 7, 8, 9), 2, 1'b0);
    rst = 1'b1;
    #1;
    n_cmp++; if ({in_ready, out_valid, out_digit, out_sign, out_last, out_err} !== 9'b0) begin n_fail++; $display("FAIL mrst_collect_outputs: got %b want 0", {in_ready, out_valid, out_digit, out_sign, out_last, out_err}); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if ({in_ready, out_valid} !== 2'b10) begin n_fail++; $display("FAIL mrst_collect_release: got %b want 10", {in_ready, out_valid}); end
    @(negedge clk);
    // Reset while the second output digit is presented.
    send_digits(w4(7, 7, 8, 9), N, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if ({out_valid, out_digit, out_sign} !== {1'b1, 4'd2, 1'b1}) begin n_fail++; $display("FAIL mrst_emit_digit1: got %b want %b", {out_valid, out_digit, out_sign}, {1'b1, 4'd2, 1'b1}); end
    rst = 1'b1;
    #1;
    n_cmp++; if ({in_ready, out_valid, out_digit, out_sign, out_last, out_err} !== 9'b0) begin n_fail++; $display("FAIL mrst_emit_outputs: got %b want 0", {in_ready, out_valid, out_digit, out_sign, out_last, out_err}); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if ({in_ready, out_valid} !== 2'b10) begin n_fail++; $display("FAIL mrst_emit_release: got %b want 10", {in_ready, out_valid}); end
    @(negedge clk);
    w = w4(3, 2, 1, 0);
    sb.push_back(model(w));
    send_digits(w, N, 1'b0);
    recv_word(od, os, ol, oe, ok);
    e = sb.pop_front();
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL mrst_timeout: got %b want 1", ok); end
    n_cmp++; if (od !== e.mag) begin n_fail++; $display("FAIL mrst_word: got %h want %h", od, e.mag); end
    n_cmp++; if (os !== {N{e.sign}}) begin n_fail++; $display("FAIL mrst_sign: got %b want %b", os, {N{e.sign}}); end
    n_cmp++; if (oe !== 4'b0000) begin n_fail++; $display("FAIL mrst_err: got %b want 0000", oe); end
    n_cmp++; if (ol !== 4'b1000) begin n_fail++; $display("FAIL mrst_last: got %b want 1000", ol); end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_decode();
    test_backpressure();
    test_invalid();
    test_mid_reset();
    n_cmp++; if (sb.size() !== 0) begin n_fail++; $display("FAIL scoreboard_empty: got %0d want 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
